// File: rtl/imem_loader_pkg.sv
// Shared types and error codes for the UART program-image loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte-lane packer with running XOR checksum.
// word_next is the word including the current byte, so the parent can latch it on word_rdy.
module loader_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_stb,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_rdy,
    output logic [7:0]  csum
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            word_q <= '0;
            csum_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            csum_q <= csum_d;
        end
    end

    always_comb begin
        lane_d    = lane_q;
        word_d    = word_q;
        csum_d    = csum_q;
        word_next = word_q;
        word_next[{lane_q, 3'b000} +: 8] = byte_in;
        word_rdy  = byte_stb && !clr && (lane_q == 2'd3);
        if (clr) begin
            lane_d = '0;
            word_d = '0;
            csum_d = '0;
        end else if (byte_stb) begin
            lane_d = lane_q + 2'd1;
            word_d = word_next;
            csum_d = csum_q ^ byte_in;
        end
    end

    assign csum = csum_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Frames UART bytes (sync, count, LE words, XOR checksum) into instruction-memory writes.
//   state  | meaning
//   IDLE   | waiting for sync byte
//   CNT_LO | expecting count[7:0]
//   CNT_HI | expecting count[15:8], range check
//   DATA   | packing data words, one write per 4 bytes
//   CSUM   | expecting checksum byte
//   DONE   | one-cycle clean completion
//   ERR    | one-cycle error exit
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         IMEM_WORDS     = 1024,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [3:0]  imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        prog_ena,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int IDX_W = $clog2(IMEM_WORDS) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t     state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  gap_q, gap_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       din_q, din_d;

    logic              sync_acc;
    logic              in_frame;
    logic [15:0]       count_full;
    logic [31:0]       word_next;
    logic              word_rdy;
    logic [7:0]        csum;

    assign sync_acc   = (state_q == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    assign in_frame   = state_q inside {CNT_LO, CNT_HI, DATA, CSUM};
    assign count_full = {rx_data, cnt_q[7:0]};

    loader_word_packer u_packer (
        .clk       (clk),
        .rst_n     (Rst_n),
        .clr       (sync_acc),
        .byte_stb  ((state_q == DATA) && rx_valid),
        .byte_in   (rx_data),
        .word_next (word_next),
        .word_rdy  (word_rdy),
        .csum      (csum)
    );

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            we_q       <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        we_d       = '0;
        addr_d     = addr_q;
        din_d      = din_q;

        // Gap timer counts down from the limit; a byte always reloads it.
        if (in_frame) begin
            if (rx_valid)
                gap_d = TMO_W'(TIMEOUT_CYCLES);
            else if (gap_q != '0)
                gap_d = gap_q - TMO_W'(1);
        end

        case (state_q)
            IDLE: if (sync_acc) begin
                state_d    = CNT_LO;
                err_d      = 1'b0;
                err_code_d = ERR_NONE;
                idx_d      = '0;
                cnt_d      = '0;
                gap_d      = TMO_W'(TIMEOUT_CYCLES);
            end
            CNT_LO: if (rx_valid) begin
                cnt_d[7:0] = rx_data;
                state_d    = CNT_HI;
            end
            CNT_HI: if (rx_valid) begin
                cnt_d = count_full;
                if ({16'd0, count_full} > 32'(IMEM_WORDS)) begin
                    state_d    = ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_OVF;
                end else if (count_full == 16'd0) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (word_rdy) begin
                we_d   = 4'hF;
                din_d  = word_next;
                addr_d = 32'(idx_q) << 2;
                idx_d  = idx_q + IDX_W'(1);
                if (16'(idx_q) + 16'd1 == cnt_q)
                    state_d = CSUM;
            end
            CSUM: if (rx_valid) begin
                if (rx_data == csum) begin
                    state_d = DONE;
                end else begin
                    state_d    = ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_CSUM;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (in_frame && !rx_valid && (gap_q == '0)) begin
            state_d    = ERR;
            err_d      = 1'b1;
            err_code_d = ERR_TMO;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        prog_ena = state_q inside {CNT_LO, CNT_HI, DATA, CSUM, DONE};
    end

    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_din  = din_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized and directed frames against a byte-stream parsing model of the loader.
module tb_imem_uart_loader;

    localparam int         T    = 16;
    localparam int         W    = 1024;
    localparam logic [7:0] SYNC = 8'h55;

    logic        clk   = 1'b0;
    logic        Rst_n = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic [3:0]  imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        prog_ena;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    imem_uart_loader #(
        .SYNC_BYTE      (SYNC),
        .IMEM_WORDS     (W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_din  (imem_din),
        .prog_ena  (prog_ena),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write / done capture
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int bad_we    = 0;
    int done_n    = 0;
    int done_nope = 0;

    always @(negedge clk) begin
        if (imem_we != 4'h0) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_din);
            if (imem_we != 4'hF) bad_we++;
        end
        if (done) begin
            done_n++;
            if (!prog_ena) done_nope++;
        end
    end

    // Stimulus frame: bytes and idle cycles before each byte
    logic [7:0]  fb[$];
    int          fg[$];
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    int          e_done;
    logic        e_err = 1'b0;
    logic [1:0]  e_code = 2'b00;
    int          e_sync;

    task automatic push(input logic [7:0] b, input int g);
        fb.push_back(b);
        fg.push_back(g);
    endtask

    task automatic clear_frame();
        fb.delete();
        fg.delete();
    endtask

    // Parses the byte stream by position after the first sync byte.
    task automatic model();
        int          cnt;
        int          p;
        int          d;
        logic [7:0]  cs;
        logic [31:0] w;
        ea.delete();
        ed.delete();
        e_done = 0;
        e_sync = -1;
        cnt = 0;
        cs  = 8'h00;
        w   = 32'h0;
        for (int i = 0; i < fb.size(); i++)
            if (fb[i] == SYNC) begin
                e_sync = i;
                break;
            end
        if (e_sync < 0) return;
        e_err  = 1'b0;
        e_code = 2'b00;
        for (int i = e_sync + 1; i <= fb.size(); i++) begin
            if (i == fb.size() || fg[i] > T) begin
                e_err  = 1'b1;
                e_code = 2'b11;
                return;
            end
            p = i - e_sync - 1;
            if (p == 0) begin
                cnt = int'(fb[i]);
            end else if (p == 1) begin
                cnt = cnt + 256 * int'(fb[i]);
                if (cnt > W) begin
                    e_err  = 1'b1;
                    e_code = 2'b10;
                    return;
                end
            end else if (p < 2 + 4 * cnt) begin
                d = p - 2;
                w[8*(d%4) +: 8] = fb[i];
                cs = cs ^ fb[i];
                if (d % 4 == 3) begin
                    ea.push_back(32'(d / 4) * 32'd4);
                    ed.push_back(w);
                end
            end else begin
                if (fb[i] == cs) begin
                    e_done = 1;
                end else begin
                    e_err  = 1'b1;
                    e_code = 2'b01;
                end
                return;
            end
        end
    endtask

    task automatic tick(inout int pend);
        @(negedge clk);
        if (pend == 1)      chk("busy_noise", 32'(busy), 32'd0);
        else if (pend == 2) chk("prog_ena_rise", 32'(prog_ena), 32'd1);
        pend = 0;
    endtask

    task automatic run_frame(input string tag);
        int pend;
        int n;
        model();
        wa_q.delete();
        wd_q.delete();
        done_n    = 0;
        bad_we    = 0;
        done_nope = 0;
        pend      = 0;
        for (int i = 0; i < fb.size(); i++) begin
            for (int g = 0; g < fg[i]; g++) begin
                tick(pend);
                rx_valid = 1'b0;
            end
            tick(pend);
            rx_valid = 1'b1;
            rx_data  = fb[i];
            pend = (i < e_sync) ? 1 : ((i == e_sync) ? 2 : 0);
        end
        tick(pend);
        rx_valid = 1'b0;
        repeat (T + 8) @(negedge clk);
        chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(ea.size()));
        n = (wa_q.size() < ea.size()) ? wa_q.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, wa_q[i], ea[i]);
            chk({tag, "_data"}, wd_q[i], ed[i]);
        end
        chk({tag, "_done"}, 32'(done_n), 32'(e_done));
        chk({tag, "_err"}, 32'(err), 32'(e_err));
        chk({tag, "_code"}, 32'(err_code), 32'(e_code));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pe_end"}, 32'(prog_ena), 32'd0);
        chk({tag, "_we_full"}, 32'(bad_we), 32'd0);
        chk({tag, "_done_pe"}, 32'(done_nope), 32'd0);
    endtask

    function automatic int rand_gap();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return 0;
        if (r < 9) return int'($urandom_range(1, 4));
        return T;
    endfunction

    task automatic gen_random();
        int          cnt;
        int          k;
        logic [7:0]  b;
        logic [7:0]  cs;
        clear_frame();
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h00;
            push(b, int'($urandom_range(0, 3)));
        end
        push(SYNC, int'($urandom_range(0, 3)));
        if ($urandom_range(0, 9) == 0) cnt = int'($urandom_range(W + 1, 65535));
        else                           cnt = int'($urandom_range(0, 5));
        push(8'(cnt), rand_gap());
        push(8'(cnt >> 8), rand_gap());
        if (cnt > W) return;
        cs = 8'h00;
        for (int i = 0; i < 4 * cnt; i++) begin
            b = 8'($urandom_range(0, 255));
            cs = cs ^ b;
            push(b, rand_gap());
        end
        if ($urandom_range(0, 4) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
        push(cs, rand_gap());
        if ($urandom_range(0, 6) == 0) begin
            k = int'($urandom_range(fb.size() - 3, fb.size() - 1));
            while (fb.size() > k) begin
                void'(fb.pop_back());
                void'(fg.pop_back());
            end
        end
    endtask

    task automatic two_word_frame(input logic [7:0] csum);
        clear_frame();
        push(SYNC, 0);
        push(8'h02, 0); push(8'h00, 0);
        push(8'h13, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
        push(8'h93, 0); push(8'h00, 0); push(8'h10, 0); push(8'h00, 0);
        push(csum, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;
        #1 Rst_n = 1'b0;
        #2;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_din", imem_din, 32'd0);
        chk("rst_pe", 32'(prog_ena), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        repeat (3) @(negedge clk);
        Rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // XOR of 13,00,00,00,93,00,10,00 is 0x90
        two_word_frame(8'h90);
        run_frame("clean2");
        two_word_frame(8'h91);
        run_frame("badcsum");
        two_word_frame(8'h90);
        run_frame("clean_after_err");

        clear_frame();
        push(SYNC, 0); push(8'h01, 0); push(8'h04, 0);
        run_frame("ovf1025");

        clear_frame();
        push(SYNC, 0); push(8'h00, 0); push(8'h04, 0);
        cs = 8'h00;
        for (int i = 0; i < 4 * W; i++) begin
            push(8'(i * 7 + 3), 0);
            cs = cs ^ 8'(i * 7 + 3);
        end
        push(cs, 0);
        run_frame("max1024");

        clear_frame();
        push(SYNC, 0); push(8'h01, 0); push(8'h00, 0); push(8'hAA, 0);
        run_frame("tmo_stop");

        clear_frame();
        push(SYNC, 0); push(8'h01, 0); push(8'h00, 0); push(8'hAA, 0);
        push(8'h11, T + 1);
        run_frame("tmo_gap");

        clear_frame();
        push(SYNC, 0); push(8'h01, T); push(8'h00, 0);
        push(8'h01, 0); push(8'h02, T); push(8'h03, 0); push(8'h04, 0);
        push(8'h04, T);
        run_frame("gap_edge");

        clear_frame();
        push(8'h77, 0); push(8'h12, 2);
        push(SYNC, 1); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
        run_frame("zero_len");

        clear_frame();
        push(SYNC, 0); push(8'h01, 0);
        run_frame("tmo_pre_rst");

        // Reset after the second data byte of a two-word frame
        foreach (fb[i]) ;
        rx_data = SYNC; rx_valid = 1'b1; @(negedge clk);
        rx_data = 8'h02; @(negedge clk);
        rx_data = 8'h00; @(negedge clk);
        rx_data = 8'h13; @(negedge clk);
        rx_data = 8'h00; @(negedge clk);
        rx_valid = 1'b0;
        wa_q.delete();
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_pe", 32'(prog_ena), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_code", 32'(err_code), 32'd0);
        chk("midrst_we", 32'(imem_we), 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        chk("midrst_din", imem_din, 32'd0);
        repeat (3) @(negedge clk);
        Rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_nowr", 32'(wa_q.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        e_err  = 1'b0;
        e_code = 2'b00;
        two_word_frame(8'h90);
        run_frame("after_rst");

        for (int n = 0; n < 30; n++) begin
            gen_random();
            run_frame("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
